// File: rtl/full_adder_if.sv
// full_adder_if -- operand/result bundle for the registered full adder.
//
// Parameter:
//   WIDTH      operand and sum width in bits (1..64)
//
// Signals:
//   in_valid   qualifies a, b and cin this cycle
//   a, b       unsigned operands, WIDTH bits
//   cin        carry into bit 0
//   out_valid  sum/carry hold a valid result
//   sum        (a + b + cin) mod 2^WIDTH
//   carry      carry out of bit WIDTH-1
//
// Modports:
//   master     the side that supplies operands and consumes results
//   slave      the adder itself
interface full_adder_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output in_valid, a, b, cin,
    input  out_valid, sum, carry
  );

  modport slave (
    input  in_valid, a, b, cin,
    output out_valid, sum, carry
  );
endinterface

// File: rtl/full_adder.sv
// full_adder -- registered ripple-carry adder.
//
// WIDTH one-bit full-adder cells form a combinational ripple chain; the
// result {carry, sum} = a + b + cin, together with in_valid, then passes
// through PIPE output register stages. One new operation can enter every
// clock; there are no stalls.
//
// Parameters:
//   WIDTH  operand and sum width in bits (1..64)
//   PIPE   number of output register stages (1..4); latency in clocks
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears every stage immediately
//   bus    full_adder_if slave: in_valid/a/b/cin in, out_valid/sum/carry out
module full_adder #(
  parameter int WIDTH = 1,
  parameter int PIPE  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  full_adder_if.slave  bus
);

  // c_chain[i] is the carry into cell i; c_chain[WIDTH] is the final carry.
  logic [WIDTH:0]   c_chain;
  logic [WIDTH-1:0] sum_d;
  logic             carry_d;

  assign c_chain[0] = bus.cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    assign sum_d[gi]       = bus.a[gi] ^ bus.b[gi] ^ c_chain[gi];
    assign c_chain[gi + 1] = (bus.a[gi] & bus.b[gi])
                           | (bus.a[gi] & c_chain[gi])
                           | (bus.b[gi] & c_chain[gi]);
  end

  assign carry_d = c_chain[WIDTH];

  // Stage 0 samples the adder every cycle, valid or not; the data is simply
  // don't-care while its valid bit is 0. Later stages shift unconditionally.
  logic             valid_q [PIPE];
  logic [WIDTH-1:0] sum_q   [PIPE];
  logic             carry_q [PIPE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE; i++) begin
        valid_q[i] <= 1'b0;
        sum_q[i]   <= '0;
        carry_q[i] <= 1'b0;
      end
    end else begin
      valid_q[0] <= bus.in_valid;
      sum_q[0]   <= sum_d;
      carry_q[0] <= carry_d;
      for (int i = 1; i < PIPE; i++) begin
        valid_q[i] <= valid_q[i-1];
        sum_q[i]   <= sum_q[i-1];
        carry_q[i] <= carry_q[i-1];
      end
    end
  end

  // Outputs come straight from the last stage: no input-to-output path.
  assign bus.out_valid = valid_q[PIPE-1];
  assign bus.sum       = sum_q[PIPE-1];
  assign bus.carry     = carry_q[PIPE-1];

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Three configurations under test.
  full_adder_if #(.WIDTH(1)) if1 ();
  full_adder_if #(.WIDTH(8)) if8 ();
  full_adder_if #(.WIDTH(4)) if4 ();

  full_adder #(.WIDTH(1), .PIPE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  full_adder #(.WIDTH(8), .PIPE(2)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  full_adder #(.WIDTH(4), .PIPE(3)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", name, act, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " d1 valid"}, 64'(if1.out_valid), 64'd0);
    check({tag, " d1 sum"},   64'(if1.sum),       64'd0);
    check({tag, " d1 carry"}, 64'(if1.carry),     64'd0);
    check({tag, " d8 valid"}, 64'(if8.out_valid), 64'd0);
    check({tag, " d8 sum"},   64'(if8.sum),       64'd0);
    check({tag, " d8 carry"}, 64'(if8.carry),     64'd0);
    check({tag, " d4 valid"}, 64'(if4.out_valid), 64'd0);
    check({tag, " d4 sum"},   64'(if4.sum),       64'd0);
    check({tag, " d4 carry"}, 64'(if4.carry),     64'd0);
  endtask

  vec_t       tt [8];
  vec_t       wv [5];
  logic [3:0] ra [16];
  logic [3:0] rb [16];
  logic       rc [16];
  logic       pat [12];

  initial begin
    // Truth table, order a b cin = 000..111, hand-computed results.
    tt[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0};
    tt[1] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b0};
    tt[2] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b0};
    tt[3] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1};
    tt[4] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0};
    tt[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b1};
    tt[6] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b1};
    tt[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1};
    // 8-bit ripple vectors.
    wv[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    wv[1] = '{8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0};
    wv[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    wv[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    wv[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

    idle_all();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset held");

    // Release between edges, then align to posedge+1.
    @(posedge clk);
    #5 rst_n = 1'b1;
    tick();

    // ---- Truth table, WIDTH=1 PIPE=1, back to back ----
    for (int i = 0; i < 8; i++) begin
      if1.in_valid = 1'b1;
      if1.a = tt[i].a[0]; if1.b = tt[i].b[0]; if1.cin = tt[i].cin;
      tick();
      check($sformatf("tt%0d valid", i), 64'(if1.out_valid), 64'd1);
      check($sformatf("tt%0d sum", i),   64'(if1.sum),       64'(tt[i].s[0]));
      check($sformatf("tt%0d carry", i), 64'(if1.carry),     64'(tt[i].c));
    end
    idle_all();
    tick();
    check("tt drain valid", 64'(if1.out_valid), 64'd0);

    // ---- Wide ripple, WIDTH=8 PIPE=2 ----
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        if8.in_valid = 1'b1;
        if8.a = wv[i].a; if8.b = wv[i].b; if8.cin = wv[i].cin;
      end else begin
        if8.in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        check($sformatf("w8 v%0d valid", i-1), 64'(if8.out_valid), 64'd1);
        check($sformatf("w8 v%0d sum", i-1),   64'(if8.sum),       64'(wv[i-1].s));
        check($sformatf("w8 v%0d carry", i-1), 64'(if8.carry),     64'(wv[i-1].c));
      end
    end
    tick();
    check("w8 drain valid", 64'(if8.out_valid), 64'd0);

    // ---- Back to back, WIDTH=4 PIPE=3 ----
    for (int i = 0; i < 16; i++) begin
      ra[i] = 4'($urandom_range(0, 15));
      rb[i] = 4'($urandom_range(0, 15));
      rc[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i <= 18; i++) begin
      if (i < 16) begin
        if4.in_valid = 1'b1;
        if4.a = ra[i]; if4.b = rb[i]; if4.cin = rc[i];
      end else begin
        if4.in_valid = 1'b0;
      end
      tick();
      if (i >= 2) begin
        int j;
        logic [4:0] exp5;
        j = i - 2;
        if (j < 16) begin
          exp5 = 5'(ra[j]) + 5'(rb[j]) + 5'(rc[j]);
          check($sformatf("b2b%0d valid", j), 64'(if4.out_valid), 64'd1);
          check($sformatf("b2b%0d sum", j),   64'(if4.sum),       64'(exp5[3:0]));
          check($sformatf("b2b%0d carry", j), 64'(if4.carry),     64'(exp5[4]));
        end else begin
          check($sformatf("b2b tail%0d valid", j), 64'(if4.out_valid), 64'd0);
        end
      end
    end

    // ---- Valid gating on PIPE=1 and PIPE=3 ----
    for (int i = 0; i < 12; i++) pat[i] = (i < 10) && (i % 2 == 0);
    for (int i = 0; i < 12; i++) begin
      if1.in_valid = pat[i]; if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b0;
      if4.in_valid = pat[i]; if4.a = 4'd1; if4.b = 4'd1; if4.cin = 1'b0;
      tick();
      check($sformatf("gate d1 c%0d valid", i), 64'(if1.out_valid), 64'(pat[i]));
      if (pat[i]) begin
        check($sformatf("gate d1 c%0d sum", i),   64'(if1.sum),   64'd0);
        check($sformatf("gate d1 c%0d carry", i), 64'(if1.carry), 64'd1);
      end
      if (i >= 2) begin
        check($sformatf("gate d4 c%0d valid", i), 64'(if4.out_valid), 64'(pat[i-2]));
        if (pat[i-2]) begin
          check($sformatf("gate d4 c%0d sum", i),   64'(if4.sum),   64'd2);
          check($sformatf("gate d4 c%0d carry", i), 64'(if4.carry), 64'd0);
        end
      end
    end
    idle_all();

    // ---- Reset mid-stream ----
    for (int i = 0; i < 3; i++) begin
      if1.in_valid = 1'b1; if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b1;
      if8.in_valid = 1'b1; if8.a = 8'hF0; if8.b = 8'h0F; if8.cin = 1'b1;
      if4.in_valid = 1'b1; if4.a = 4'd7; if4.b = 4'd6; if4.cin = 1'b1;
      tick();
    end
    check("pre-reset d4 valid", 64'(if4.out_valid), 64'd1);
    check("pre-reset d1 sum",   64'(if1.sum),       64'd1);
    idle_all();
    #4 rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    @(posedge clk);
    #1;
    check_all_zero("reset over edge");
    #4 rst_n = 1'b1;
    tick();
    check("post-release d4 valid", 64'(if4.out_valid), 64'd0);
    if4.in_valid = 1'b1; if4.a = 4'd9; if4.b = 4'd8; if4.cin = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      idle_all();
      if (k < 3) begin
        check($sformatf("restart k%0d valid", k), 64'(if4.out_valid), 64'd0);
      end else begin
        check("restart valid", 64'(if4.out_valid), 64'd1);
        check("restart sum",   64'(if4.sum),       64'd2);
        check("restart carry", 64'(if4.carry),     64'd1);
      end
    end
    tick();
    check("restart drain valid", 64'(if4.out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered full adder: sum and carry-out of operands a, b and carry-in cin.
- Default WIDTH=1 is the classic 1-bit full adder cell. Larger WIDTH gives a ripple-carry adder built from 1-bit full-adder cells.
- Result goes through PIPE register stages with a valid flag, so it can drop into a clocked datapath.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.
- PIPE, 1, number of output register stages; legal range 1..4.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies a, b, cin this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in into bit 0.
- out_valid  output  1  sum/carry hold a valid result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- carry  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (rst_n low): all pipeline registers clear at once, without waiting for clk. While held, out_valid=0, sum=0, carry=0.
- Reset release: first register update on the first rising clk edge with rst_n high.
- Per-cell logic, bit i: s_i = a_i ^ b_i ^ c_i and c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i. c_0 = cin, carry = c_WIDTH.
- The ripple chain is combinational; only the outputs are registered.
- Latency: exactly PIPE rising edges from input sample to output.
- Stage 1 captures {in_valid, sum, carry} on every rising edge. Each later stage copies the previous stage.
- in_valid=0: stage 1 still captures its valid bit as 0. Sum/carry data registers still update; the data is don't-care while out_valid=0.
- Throughput: one new operation per clock, no stalls, no backpressure.
- Arithmetic: unsigned; {carry, sum} = a + b + cin exactly (WIDTH+1 bits). Overflow appears only on carry; no saturation.
- Boundaries:
  - all ones + cin=1 gives sum=all ones, carry=1.
  - all zeros + cin=0 gives sum=0, carry=0.
- Reset mid-operation: every in-flight result is discarded; out_valid stays 0 until new valid inputs have travelled PIPE cycles after release.
- Outputs are driven only from registers; there is no combinational input-to-output path.

Test Plan:
- Truth table (WIDTH=1, PIPE=1): apply all 8 combos of a/b/cin in order 000,001,010,011,100,101,110,111 with in_valid=1, 10 ns apart. One cycle later, sum/carry must read 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1.
- Reset: pulse rst_n low between clock edges mid-stream -> sum=0, carry=0, out_valid=0 immediately. First valid output appears PIPE cycles after new inputs following release.
- Valid gating: alternate in_valid 1/0 with a=1, b=1, cin=0 -> out_valid shows the same alternating pattern delayed by PIPE. Every out_valid=1 cycle shows sum=0, carry=1.
- Wide ripple (WIDTH=8, PIPE=2):
  - a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, carry=1, two cycles later.
  - a=8'h5A, b=8'hA5, cin=0 -> sum=8'hFF, carry=0.
- Back-to-back (WIDTH=4, PIPE=3): 16 random valid vectors on consecutive cycles -> each result matches a+b+cin exactly 3 cycles later, no gaps or repeats.
